forloop_generate_check: RTL and testbench
=========================================

# forloop_generate_check

Receive-side checker for the alternating-bit test pattern driven by the per-bit generate-loop pattern generator. The generator drives bit j = j%2, which is 0xAAAAAAAA at WIDTH=32, and drives all-zero while in reset. This block consumes those words, acquires lock on the pattern and counts mismatches. It keeps per-bit sticky error flags, and it is the other end of the same test link in the TMR/generate regression designs.

## Interface
Parameters:
- WIDTH, 32, data width; expected pattern bit j = j%2
- LOCK_CNT, 4, consecutive correct words required to lock (≥1)
- LOSS_CNT, 4, consecutive bad words while locked to drop lock (≥1)
- ERR_CNT_W, 16, width of saturating error counter

Ports:
- c, input, 1, clock; all state updates on posedge c
- r, input, 1, reset, synchronous, active-high
- d, input, WIDTH, data word from generator
- valid, input, 1, d is sampled only when valid=1
- clr, input, 1, clears err_bits and err_cnt (not lock state)
- locked, output, 1, pattern lock acquired
- err, output, 1, one-cycle pulse per mismatching valid word while locked
- err_bits, output, WIDTH, sticky OR of (d ^ EXP) over mismatches while locked
- err_cnt, output, ERR_CNT_W, saturating count of mismatching words while locked

## Operation
- EXP is a constant: bit j = j%2.
- Mismatch: valid=1 and d != EXP. A zero word counts as a mismatch.
- FSM state SEARCH (reset state), locked=0:
  - A matching word increments match_cnt.
  - A mismatch clears match_cnt to 0.
  - A match when match_cnt = LOCK_CNT-1 moves to LOCKED and clears match_cnt.
  - Errors are not recorded in SEARCH.
- FSM state LOCKED, locked=1:
  - A mismatch causes: err=1, err_bits |= d^EXP, err_cnt += 1 (saturating at all-ones), loss_cnt += 1.
  - A match clears loss_cnt.
  - A mismatch when loss_cnt = LOSS_CNT-1 goes to SEARCH and clears loss_cnt. That final word is still recorded as an error.
- valid=0 holds all state. It does not break match or loss runs.
- clr and a recorded mismatch in the same cycle: err_bits loads d^EXP and err_cnt loads 1. clr has no effect on FSM, match_cnt or loss_cnt.
- err_bits is built with a generate-for, one always block per bit, with the same per-bit clear and sticky-set logic.

## Timing
- All outputs are registered. Latency is 1 cycle from the valid word edge to the locked, err, err_bits and err_cnt update.
- err is high for exactly the cycle after each recorded mismatch. Back-to-back mismatches give back-to-back pulses.
- locked rises at the edge that samples the LOCK_CNT-th consecutive match. It falls at the edge that samples the LOSS_CNT-th consecutive mismatch, and err is also 1 in the cycle that follows that edge.
- Reset, r=1 at an edge, in any state including mid-lock:
  - State goes to SEARCH; match_cnt and loss_cnt go to 0.
  - locked, err, err_bits and err_cnt all go to 0.
  - r overrides valid and clr.
- Saturation: err_cnt stays at 2^ERR_CNT_W-1. err still pulses and err_bits still accumulates.

## Structure
- Package forloop_generate_pkg holds:
  - a state enum {SEARCH, LOCKED};
  - a function exp_pattern(int w) that returns the j%2 word, shared with the generator bench.
- No sub-module: the FSM and counters are inline, and the per-bit sticky logic uses the generate-for inside this module.
- The counters are sized $clog2(LOCK_CNT+1) and $clog2(LOSS_CNT+1).

## Test plan
All values are at default parameters unless stated.
- Reset: hold r for 3 cycles with random d → locked=0, err=0, err_bits=0, err_cnt=0.
- Lock: 4 valid 0xAAAAAAAA words → locked=1 the cycle after the 4th. Insert one 0x0 after the 3rd match → lock needs 4 more matches.
- Single-bit error while locked: d=0xAAAAAAA2 → err pulses 1 cycle, err_bits=0x00000008, err_cnt=1, locked stays 1.
- Loss: 4 consecutive 0x00000000 words while locked → err_cnt=4, err_bits=0xAAAAAAAA, locked=0 after the 4th. The next 3 matches do not relock; the 4th does.
- Saturation with ERR_CNT_W=4: 20 mismatches interleaved with matches → err_cnt=15, 20 err pulses.
- clr with mismatch in the same cycle, d=0xAAAAAAAB → err_bits=0x00000001, err_cnt=1. clr alone → both 0, locked unchanged. r asserted mid-lock → all outputs 0 next cycle.

Source files
------------

// File: rtl/forloop_generate_pkg.sv
// Shared definitions for the alternating-bit test link (generator and checker).
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package forloop_generate_pkg;

   // Upper bound on the pattern width the helper can produce.
   localparam int MAX_W = 1024;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   // Expected link word: bit j carries j%2, so bits above w stay 0.
   function automatic logic [MAX_W-1:0] exp_pattern(int w);
      logic [MAX_W-1:0] p;
      p = '0;
      for (int j = 0; j < MAX_W; j++) begin
         if (j < w) p[j] = 1'(j % 2);
      end
      return p;
   endfunction

endpackage

// File: rtl/forloop_generate_check.sv
// Receive-side checker: locks onto the alternating-bit pattern and records mismatches.
// Latency: 1 cycle from the sampled word to locked/err/err_bits/err_cnt.
// Backpressure: none; the checker always accepts, and valid=0 simply holds all state.
module forloop_generate_check
   import forloop_generate_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LOCK_CNT  = 4,
   parameter int LOSS_CNT  = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 c,
   input  logic                 r,
   input  logic [WIDTH-1:0]     d,
   input  logic                 valid,
   input  logic                 clr,
   output logic                 locked,
   output logic                 err,
   output logic [WIDTH-1:0]     err_bits,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);
   localparam logic [WIDTH-1:0] EXP = WIDTH'(exp_pattern(WIDTH));

   chk_state_e           state_q, state_d;
   logic [MW-1:0]        match_cnt_q, match_cnt_d;
   logic [LW-1:0]        loss_cnt_q, loss_cnt_d;
   logic                 locked_q;
   logic                 err_q;
   logic [WIDTH-1:0]     err_bits_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   logic [WIDTH-1:0]     diff;
   logic                 is_match;
   logic                 is_mism;
   logic                 rec;

   assign diff     = d ^ EXP;
   assign is_match = valid && (diff == '0);
   assign is_mism  = valid && (diff != '0);
   // Errors only count once the link is locked; SEARCH mismatches just restart the run.
   assign rec      = is_mism && (state_q == LOCKED);

   // State and run-length registers.
   always_ff @(posedge c) begin
      if (r) begin
         state_q     <= SEARCH;
         match_cnt_q <= '0;
         loss_cnt_q  <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         locked_q    <= (state_d == LOCKED);
         err_q       <= rec;
      end
   end

   // Lock acquisition/loss: consecutive-run counters, untouched by clr.
   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      loss_cnt_d  = loss_cnt_q;
      case (state_q)
         SEARCH: begin
            if (is_match) begin
               if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
                  state_d     = LOCKED;
                  match_cnt_d = '0;
               end else begin
                  match_cnt_d = match_cnt_q + MW'(1);
               end
            end else if (is_mism) begin
               match_cnt_d = '0;
            end
         end
         LOCKED: begin
            if (is_mism) begin
               if (loss_cnt_q == LW'(LOSS_CNT - 1)) begin
                  state_d    = SEARCH;
                  loss_cnt_d = '0;
               end else begin
                  loss_cnt_d = loss_cnt_q + LW'(1);
               end
            end else if (is_match) begin
               loss_cnt_d = '0;
            end
         end
         default: begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            loss_cnt_d  = '0;
         end
      endcase
   end

   // Saturating error counter; a same-cycle clr restarts the count at this error.
   always_ff @(posedge c) begin
      if (r) begin
         err_cnt_q <= '0;
      end else if (rec) begin
         if (clr)                  err_cnt_q <= ERR_CNT_W'(1);
         else if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end else if (clr) begin
         err_cnt_q <= '0;
      end
   end

   // Per-bit sticky flags, one register per bit lane.
   for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      // Bit j: clear on clr, then set if this recorded word differs in bit j.
      always_ff @(posedge c) begin
         if (r) begin
            err_bits_q[j] <= 1'b0;
         end else if (rec) begin
            err_bits_q[j] <= (err_bits_q[j] & ~clr) | diff[j];
         end else if (clr) begin
            err_bits_q[j] <= 1'b0;
         end
      end
   end

   assign locked   = locked_q;
   assign err      = err_q;
   assign err_bits = err_bits_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_forloop_generate_check.sv
// Self-checking bench: two checker instances (16-bit and 4-bit error counters) share stimulus.
// A reference model of the lock/error rules is compared every cycle; literals pin key points.
// Directed scenarios are followed by a mixed pseudo-random phase.
module tb_forloop_generate_check;

   localparam logic [31:0] PAT = 32'hAAAA_AAAA;

   logic        c;
   logic        tr, tv, tclr;
   logic [31:0] td;

   logic        lk0, er0, lk1, er1;
   logic [31:0] eb0, eb1;
   logic [15:0] ec0;
   logic [3:0]  ec1;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   forloop_generate_check u0 (
      .c(c), .r(tr), .d(td), .valid(tv), .clr(tclr),
      .locked(lk0), .err(er0), .err_bits(eb0), .err_cnt(ec0)
   );

   forloop_generate_check #(.ERR_CNT_W(4)) u1 (
      .c(c), .r(tr), .d(td), .valid(tv), .clr(tclr),
      .locked(lk1), .err(er1), .err_bits(eb1), .err_cnt(ec1)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   // Reference model: run lengths, lock flag and an unbounded error count.
   bit          m_lock;
   int          m_good, m_bad;
   bit          m_err;
   logic [31:0] m_bits;
   longint      m_cnt;

   always @(posedge c) begin
      logic [31:0] dif;
      if (tr) begin
         m_lock = 0; m_good = 0; m_bad = 0; m_err = 0; m_bits = '0; m_cnt = 0;
      end else begin
         dif   = td ^ PAT;
         m_err = 0;
         if (tv && m_lock && dif != 0) begin
            m_err  = 1;
            m_bits = (tclr ? 32'h0 : m_bits) | dif;
            m_cnt  = tclr ? 1 : m_cnt + 1;
         end else if (tclr) begin
            m_bits = '0;
            m_cnt  = 0;
         end
         if (tv) begin
            if (!m_lock) begin
               if (dif == 0) begin
                  m_good++;
                  if (m_good == 4) begin m_lock = 1; m_good = 0; end
               end else begin
                  m_good = 0;
               end
            end else begin
               if (dif != 0) begin
                  m_bad++;
                  if (m_bad == 4) begin m_lock = 0; m_bad = 0; end
               end else begin
                  m_bad = 0;
               end
            end
         end
      end
   end

   function automatic longint sat(longint v, longint mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic cmp(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge c) begin
      if (chk_en) begin
         cmp("m_locked0", lk0, m_lock);
         cmp("m_err0",    er0, m_err);
         cmp("m_bits0",   eb0, m_bits);
         cmp("m_cnt0",    ec0, sat(m_cnt, 65535));
         cmp("m_locked1", lk1, m_lock);
         cmp("m_err1",    er1, m_err);
         cmp("m_bits1",   eb1, m_bits);
         cmp("m_cnt1",    ec1, sat(m_cnt, 15));
      end
   end

   // Apply one word for one edge; returns at the next falling edge with outputs settled.
   task automatic step(input logic rr, input logic vv, input logic [31:0] dd, input logic cc);
      tr = rr; tv = vv; td = dd; tclr = cc;
      @(negedge c);
   endtask

   int pulses;

   initial begin
      tr = 1'b1; tv = 1'b0; td = '0; tclr = 1'b0;
      @(negedge c);

      // Reset with random data and strobes.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom, 1'($urandom_range(0, 1)));
      chk_en = 1;
      cmp("rst_locked", lk0, 0);
      cmp("rst_err", er0, 0);
      cmp("rst_bits", eb0, 0);
      cmp("rst_cnt", ec0, 0);

      // Three matches, a zero word, then four more matches needed.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PAT, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      cmp("zero_in_search_no_err", er0, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PAT, 1'b0);
      cmp("not_locked_after_3", lk0, 0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      cmp("gap_holds_search", lk0, 0);
      step(1'b0, 1'b1, PAT, 1'b0);
      cmp("locked_after_4", lk0, 1);

      // Single-bit error while locked.
      step(1'b0, 1'b1, 32'hAAAA_AAA2, 1'b0);
      cmp("sb_err", er0, 1);
      cmp("sb_bits", eb0, 32'h0000_0008);
      cmp("sb_cnt", ec0, 1);
      cmp("sb_locked", lk0, 1);
      step(1'b0, 1'b1, PAT, 1'b0);
      cmp("sb_err_drop", er0, 0);

      // clr alone keeps lock but empties the record.
      step(1'b0, 1'b0, 32'h0, 1'b1);
      cmp("clr_bits", eb0, 0);
      cmp("clr_cnt", ec0, 0);
      cmp("clr_locked", lk0, 1);

      // Loss of lock: four zero words, with an idle gap that must not break the run.
      step(1'b0, 1'b1, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      step(1'b0, 1'b0, PAT, 1'b0);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      cmp("loss_still_locked", lk0, 1);
      step(1'b0, 1'b1, 32'h0, 1'b0);
      cmp("loss_unlocked", lk0, 0);
      cmp("loss_err", er0, 1);
      cmp("loss_cnt", ec0, 4);
      cmp("loss_bits", eb0, 32'hAAAA_AAAA);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PAT, 1'b0);
      cmp("relock_not_yet", lk0, 0);
      step(1'b0, 1'b1, PAT, 1'b0);
      cmp("relock", lk0, 1);

      // clr together with a recorded mismatch.
      step(1'b0, 1'b1, 32'hAAAA_AAAB, 1'b1);
      cmp("clrmis_bits", eb0, 32'h0000_0001);
      cmp("clrmis_cnt", ec0, 1);
      cmp("clrmis_err", er0, 1);

      // Saturation on the 4-bit counter: 20 mismatches interleaved with matches.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 32'hAAAA_AAAE, 1'b0);
         if (er1) pulses++;
         step(1'b0, 1'b1, PAT, 1'b0);
      end
      cmp("sat_pulses", pulses, 20);
      cmp("sat_cnt4", ec1, 15);
      cmp("sat_cnt16", ec0, 21);
      cmp("sat_bits", eb1, 32'h0000_0005);
      cmp("sat_locked", lk1, 1);

      // Reset mid-lock, overriding valid and clr.
      step(1'b1, 1'b1, 32'h0, 1'b1);
      cmp("rst_mid_locked", lk0, 0);
      cmp("rst_mid_err", er0, 0);
      cmp("rst_mid_bits", eb0, 0);
      cmp("rst_mid_cnt", ec0, 0);

      // Mixed traffic checked by the model alone.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] w;
         int sel;
         sel = $urandom_range(0, 9);
         case (sel)
            5, 6:    w = PAT ^ (32'h1 << $urandom_range(0, 31));
            7:       w = 32'h0;
            8:       w = $urandom;
            default: w = PAT;
         endcase
         step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0), w,
              1'($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
